// File: rtl/mac_pkg.sv
// Shared types and helpers for the vector MAC accumulator.
// Build with MAC_SATURATE_EN defined to clamp the accumulator on overflow.
package mac_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Limits come back as the low w bits of a 64-bit word.
    function automatic logic [63:0] sat_max(input int unsigned w, input logic sm);
        if (sm) begin
            return (64'd1 << (w - 1)) - 64'd1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w, input logic sm);
        if (sm) begin
            return 64'd1 << (w - 1);
        end
        return 64'd0;
    endfunction

    function automatic bit cfg_ok(input int a_w, input int b_w,
                                  input int acc_w, input int vec_len);
        return (acc_w >= a_w + b_w) && (vec_len >= 1) && (acc_w < 64);
    endfunction

endpackage

// File: rtl/mac_vector_accumulator_if.sv
// Operand/result handshake bundle for mac_vector_accumulator.
// Master drives operands and control; slave is the accumulator.
interface mac_vector_accumulator_if #(
    parameter int A_W   = 4,
    parameter int B_W   = 4,
    parameter int ACC_W = 16,
    parameter int CNT_W = 4
);
    logic             ena;
    logic             clear;
    logic             signed_mode;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             sat_flag;
    logic [CNT_W-1:0] count;

    modport master (
        output ena, clear, signed_mode, in_valid, a, b, out_ready,
        input  in_ready, out_valid, acc_out, sat_flag, count
    );

    modport slave (
        input  ena, clear, signed_mode, in_valid, a, b, out_ready,
        output in_ready, out_valid, acc_out, sat_flag, count
    );
endinterface

// File: rtl/mac_mult_stage.sv
// S1: signed/unsigned multiply, extended to the accumulator width.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int A_W   = 4,
    parameter int B_W   = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ena,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic             i_signed,
    input  logic [A_W-1:0]   i_a,
    input  logic [B_W-1:0]   i_b,
    output logic             o_valid,
    output logic [ACC_W-1:0] o_prod
);
    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] w_prod_s;
    logic        [P_W-1:0] w_prod_u;
    logic      [ACC_W-1:0] w_ext;
    logic                  r_valid;
    logic      [ACC_W-1:0] r_prod;

    assign w_prod_s = $signed(i_a) * $signed(i_b);
    assign w_prod_u = i_a * i_b;
    assign w_ext    = i_signed ? ACC_W'(w_prod_s) : ACC_W'(w_prod_u);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_prod  <= '0;
        end else if (i_ena) begin
            if (i_flush) begin
                r_valid <= 1'b0;
                r_prod  <= '0;
            end else begin
                r_valid <= i_valid;
                if (i_valid) begin
                    r_prod <= w_ext;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_prod  = r_prod;
endmodule

// File: rtl/mac_vector_accumulator.sv
// Pipelined dot-product accumulator with valid/ready handshakes.
// MAC_SATURATE_EN: clamp on overflow instead of wrapping.
module mac_vector_accumulator
    import mac_pkg::*;
#(
    parameter int A_W     = 4,
    parameter int B_W     = 4,
    parameter int ACC_W   = 16,
    parameter int VEC_LEN = 8,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input logic clk,
    input logic rst,
    mac_vector_accumulator_if.slave bus
);
    localparam logic [CNT_W-1:0] LP_LEN  = CNT_W'(VEC_LEN);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(VEC_LEN - 1);

    if (!cfg_ok(A_W, B_W, ACC_W, VEC_LEN)) begin : g_bad_cfg
        $error("mac_vector_accumulator: illegal parameters");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic               r_mode;
    logic [ACC_W-1:0]   r_acc;
    logic               r_s2_valid;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_acc_out;
    logic               r_sat;

    logic               w_in_ready;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_load;
    logic               w_mode_eff;
    logic               w_s1_valid;
    logic [ACC_W-1:0]   w_prod;
    logic [ACC_W:0]     w_sum_u;
    logic [ACC_W-1:0]   w_sum;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_acc_nxt;

    assign w_in_ready = bus.ena && (r_state == ACCUM) && (r_count < LP_LEN);
    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;
    // The first pair of a vector uses the live mode it is latching.
    assign w_mode_eff = (r_count == '0) ? bus.signed_mode : r_mode;

    mac_mult_stage #(
        .A_W   (A_W),
        .B_W   (B_W),
        .ACC_W (ACC_W)
    ) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .i_ena    (bus.ena),
        .i_flush  (bus.clear),
        .i_valid  (w_in_xfer),
        .i_signed (w_mode_eff),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_valid  (w_s1_valid),
        .o_prod   (w_prod)
    );

    assign w_sum_u = {1'b0, r_acc} + {1'b0, w_prod};
    assign w_sum   = w_sum_u[ACC_W-1:0];
    assign w_ovf   = r_mode
                   ? ((r_acc[ACC_W-1] == w_prod[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]))
                   : w_sum_u[ACC_W];

`ifdef MAC_SATURATE_EN
    always_comb begin
        w_acc_nxt = w_sum;
        if (w_ovf) begin
            if (!r_mode || !r_acc[ACC_W-1]) begin
                w_acc_nxt = ACC_W'(sat_max(ACC_W, r_mode));
            end else begin
                w_acc_nxt = ACC_W'(sat_min(ACC_W, r_mode));
            end
        end
    end
`else
    assign w_acc_nxt = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ACCUM;
        end else if (bus.ena) begin
            r_state <= bus.clear ? ACCUM : w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            ACCUM: begin
                if (w_in_xfer && (r_count == LP_LAST)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!w_s1_valid && !r_s2_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_out_xfer) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count     <= '0;
            r_mode      <= 1'b0;
            r_acc       <= '0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc_out   <= '0;
            r_sat       <= 1'b0;
        end else if (bus.ena) begin
            if (bus.clear) begin
                r_count     <= '0;
                r_acc       <= '0;
                r_s2_valid  <= 1'b0;
                r_out_valid <= 1'b0;
                r_acc_out   <= '0;
                r_sat       <= 1'b0;
            end else begin
                if (w_in_xfer) begin
                    r_count <= r_count + 1'b1;
                    if (r_count == '0) begin
                        r_mode <= bus.signed_mode;
                    end
                end
                r_s2_valid <= w_s1_valid;
                if (w_s1_valid) begin
                    r_acc <= w_acc_nxt;
                    if (w_ovf) begin
                        r_sat <= 1'b1;
                    end
                end
                if (w_load) begin
                    r_acc_out   <= r_acc;
                    r_out_valid <= 1'b1;
                end
                if (w_out_xfer) begin
                    r_out_valid <= 1'b0;
                    r_acc       <= '0;
                    r_count     <= '0;
                    r_sat       <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.acc_out   = r_acc_out;
    assign bus.sat_flag  = r_sat;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_mac_vector_accumulator.sv
// Directed bench for mac_vector_accumulator (12-bit/len-4 and 8-bit/len-2).
// Expectations for the 8-bit overflow cases follow MAC_SATURATE_EN.
module tb_mac_vector_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   lat;

    always #5 clk = ~clk;

    mac_vector_accumulator_if #(
        .A_W(4), .B_W(4), .ACC_W(12), .CNT_W(3)
    ) bus0 ();

    mac_vector_accumulator_if #(
        .A_W(4), .B_W(4), .ACC_W(8), .CNT_W(2)
    ) bus1 ();

    mac_vector_accumulator #(
        .A_W(4), .B_W(4), .ACC_W(12), .VEC_LEN(4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    mac_vector_accumulator #(
        .A_W(4), .B_W(4), .ACC_W(8), .VEC_LEN(2)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic sm, input logic [3:0] a, input logic [3:0] b);
        int g;
        bus0.signed_mode = sm;
        bus0.a           = a;
        bus0.b           = b;
        bus0.in_valid    = 1'b1;
        g = 0;
        while (!bus0.in_ready && g < 20) begin
            tick();
            g++;
        end
        if (g >= 20) chk("in_ready_timeout", 32'(g), 0);
        tick();
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus0.out_valid && n < 12) begin
            tick();
            n++;
        end
        if (n >= 12) chk("out_valid_timeout", 32'(n), 0);
    endtask

    task automatic consume();
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
        chk("consume_ov", 32'(bus0.out_valid), 0);
        chk("consume_cnt", 32'(bus0.count), 0);
    endtask

    initial begin
        bus0.ena = 1'b1; bus0.clear = 1'b0; bus0.signed_mode = 1'b0;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b0;
        bus1.ena = 1'b1; bus1.clear = 1'b0; bus1.signed_mode = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk("rst_ov", 32'(bus0.out_valid), 0);
        chk("rst_acc", 32'(bus0.acc_out), 0);
        chk("rst_sat", 32'(bus0.sat_flag), 0);
        chk("rst_cnt", 32'(bus0.count), 0);
        chk("rst_rdy", 32'(bus0.in_ready), 1);

        // 1: unsigned 15*15 x4
        for (int i = 0; i < 4; i++) xfer(1'b0, 4'hF, 4'hF);
        bus0.in_valid = 1'b0;
        chk("s1_rdy_drain", 32'(bus0.in_ready), 0);
        wait_out(lat);
        chk("s1_lat", 32'(lat), 3);
        chk("s1_acc", 32'(bus0.acc_out), 900);
        chk("s1_sat", 32'(bus0.sat_flag), 0);
        consume();

        // 2: signed -8*7 x4, mode toggled after the first pair
        xfer(1'b1, 4'h8, 4'h7);
        for (int i = 0; i < 3; i++) xfer(1'b0, 4'h8, 4'h7);
        bus0.in_valid = 1'b0;
        wait_out(lat);
        chk("s2_acc", 32'(bus0.acc_out), 32'h0F20);
        chk("s2_sat", 32'(bus0.sat_flag), 0);
        consume();

        // 3: backpressure in HOLD
        for (int i = 0; i < 4; i++) xfer(1'b0, 4'h1, 4'h1);
        bus0.in_valid = 1'b0;
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s3_rdy_hold", 32'(bus0.in_ready), 0);
            chk("s3_acc_hold", 32'(bus0.acc_out), 4);
        end
        chk("s3_ov_hold", 32'(bus0.out_valid), 1);
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        bus0.a = 4'h2; bus0.b = 4'h3; bus0.signed_mode = 1'b0;
        tick();
        bus0.out_ready = 1'b0;
        chk("s3_ov_done", 32'(bus0.out_valid), 0);
        chk("s3_rdy_next", 32'(bus0.in_ready), 1);
        for (int i = 0; i < 4; i++) xfer(1'b0, 4'h2, 4'h3);
        bus0.in_valid = 1'b0;
        wait_out(lat);
        chk("s3_acc_next", 32'(bus0.acc_out), 24);
        consume();

        // 4: clear mid-vector
        xfer(1'b0, 4'h5, 4'h5);
        xfer(1'b0, 4'h5, 4'h5);
        bus0.in_valid = 1'b0;
        chk("s4_cnt_pre", 32'(bus0.count), 2);
        bus0.clear = 1'b1;
        tick();
        bus0.clear = 1'b0;
        chk("s4_cnt_clr", 32'(bus0.count), 0);
        for (int i = 0; i < 4; i++) tick();
        chk("s4_ov_clr", 32'(bus0.out_valid), 0);
        for (int i = 0; i < 4; i++) xfer(1'b0, 4'h1, 4'h2);
        bus0.in_valid = 1'b0;
        wait_out(lat);
        chk("s4_acc", 32'(bus0.acc_out), 8);
        consume();

        // 5: 8-bit accumulator overflow, unsigned then signed
        bus1.signed_mode = 1'b0;
        bus1.a = 4'hF; bus1.b = 4'hF;
        bus1.in_valid = 1'b1;
        tick();
        tick();
        bus1.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("s5u_ov", 32'(bus1.out_valid), 1);
`ifdef MAC_SATURATE_EN
        chk("s5u_acc", 32'(bus1.acc_out), 255);
`else
        chk("s5u_acc", 32'(bus1.acc_out), 194);
`endif
        chk("s5u_sat", 32'(bus1.sat_flag), 1);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        chk("s5u_sat_clr", 32'(bus1.sat_flag), 0);
        bus1.signed_mode = 1'b1;
        bus1.a = 4'h8; bus1.b = 4'h8;
        bus1.in_valid = 1'b1;
        tick();
        tick();
        bus1.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("s5s_ov", 32'(bus1.out_valid), 1);
`ifdef MAC_SATURATE_EN
        chk("s5s_acc", 32'(bus1.acc_out), 32'h7F);
`else
        chk("s5s_acc", 32'(bus1.acc_out), 32'h80);
`endif
        chk("s5s_sat", 32'(bus1.sat_flag), 1);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;

        // 6: reset during DRAIN, then ena low with pending input
        for (int i = 0; i < 4; i++) xfer(1'b0, 4'h3, 4'h3);
        bus0.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("s6_ov", 32'(bus0.out_valid), 0);
        chk("s6_acc", 32'(bus0.acc_out), 0);
        chk("s6_sat", 32'(bus0.sat_flag), 0);
        chk("s6_cnt", 32'(bus0.count), 0);
        bus0.ena = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.a = 4'h3; bus0.b = 4'h3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s6_rdy_off", 32'(bus0.in_ready), 0);
            chk("s6_cnt_off", 32'(bus0.count), 0);
        end
        bus0.in_valid = 1'b0;
        bus0.ena = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("s6_ov_after", 32'(bus0.out_valid), 0);
        chk("s6_cnt_after", 32'(bus0.count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
